// File: rtl/alu_arb_seq.sv
// rtl/alu_arb_seq.sv - two-requester round-robin front end sequencing ops through a shared ALU
module alu_arb_seq #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic [3:0] req0_shift,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_op,
    input  logic [3:0] req1_shift,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_s,
    output logic [3:0] alu_shift,
    input  logic [7:0] alu_y,
    input  logic       alu_cero,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_y,
    output logic [2:0] rsp_flags,
    output logic       busy,
    output logic [15:0] op_count
);

    generate
        if (LAT < 1 || LAT > 15) begin : g_lat_chk
            $error("alu_arb_seq: LAT must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        id_q, id_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [2:0]  s_q, s_d;
    logic [3:0]  sh_q, sh_d;
    logic [7:0]  y_q, y_d;
    logic [2:0]  flags_q, flags_d;
    logic [15:0] opcnt_q, opcnt_d;

    logic grant0, grant1, accept;

    // Grants are gated by rst so no ready can leak out while reset is held.
    always_comb begin
        grant0 = rst && (state_q == IDLE) && req0_valid && (!req1_valid || !prio_q);
        grant1 = rst && (state_q == IDLE) && req1_valid && (!req0_valid || prio_q);
        accept = grant0 || grant1;
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sh_d    = sh_q;
        y_d     = y_q;
        flags_d = flags_q;
        opcnt_d = opcnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    prio_d  = grant0;
                    id_d    = grant1;
                    a_d     = grant1 ? req1_a     : req0_a;
                    b_d     = grant1 ? req1_b     : req0_b;
                    s_d     = grant1 ? req1_op    : req0_op;
                    sh_d    = grant1 ? req1_shift : req0_shift;
                    cnt_d   = LAT_M1;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    y_d     = alu_y;
                    flags_d = {alu_overflow, alu_carry, alu_cero};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    opcnt_d = opcnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= 4'd0;
            id_q    <= 1'b0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            s_q     <= 3'b000;
            sh_q    <= 4'h0;
            y_q     <= 8'h00;
            flags_q <= 3'b000;
            opcnt_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sh_q    <= sh_d;
            y_q     <= y_d;
            flags_q <= flags_d;
            opcnt_q <= opcnt_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_s      = s_q;
    assign alu_shift  = sh_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_y      = y_q;
    assign rsp_flags  = flags_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = opcnt_q;

endmodule

// File: tb/tb_alu_arb_seq.sv
// tb/tb_alu_arb_seq.sv - directed scoreboard bench for alu_arb_seq at LAT=1 and LAT=3
module tb_alu_arb_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic [3:0] sh0, sh1;
    logic [7:0] sy;
    logic       scero, scarry, sov;

    logic        v0_1, v1_1, rr_1, r0_1, r1_1, rv_1, rid_1, busy_1;
    logic [7:0]  aa_1, ab_1, ry_1;
    logic [2:0]  as_1, rf_1;
    logic [3:0]  ash_1;
    logic [15:0] oc_1;

    logic        v0_3, v1_3, rr_3, r0_3, r1_3, rv_3, rid_3, busy_3;
    logic [7:0]  aa_3, ab_3, ry_3;
    logic [2:0]  as_3, rf_3;
    logic [3:0]  ash_3;
    logic [15:0] oc_3;

    alu_arb_seq #(.LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0_1), .req0_ready(r0_1), .req0_a(a0), .req0_b(b0), .req0_op(op0), .req0_shift(sh0),
        .req1_valid(v1_1), .req1_ready(r1_1), .req1_a(a1), .req1_b(b1), .req1_op(op1), .req1_shift(sh1),
        .alu_a(aa_1), .alu_b(ab_1), .alu_s(as_1), .alu_shift(ash_1),
        .alu_y(sy), .alu_cero(scero), .alu_carry(scarry), .alu_overflow(sov),
        .rsp_valid(rv_1), .rsp_ready(rr_1), .rsp_id(rid_1), .rsp_y(ry_1), .rsp_flags(rf_1),
        .busy(busy_1), .op_count(oc_1)
    );

    alu_arb_seq #(.LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .req0_valid(v0_3), .req0_ready(r0_3), .req0_a(a0), .req0_b(b0), .req0_op(op0), .req0_shift(sh0),
        .req1_valid(v1_3), .req1_ready(r1_3), .req1_a(a1), .req1_b(b1), .req1_op(op1), .req1_shift(sh1),
        .alu_a(aa_3), .alu_b(ab_3), .alu_s(as_3), .alu_shift(ash_3),
        .alu_y(sy), .alu_cero(scero), .alu_carry(scarry), .alu_overflow(sov),
        .rsp_valid(rv_3), .rsp_ready(rr_3), .rsp_id(rid_3), .rsp_y(ry_3), .rsp_flags(rf_3),
        .busy(busy_3), .op_count(oc_3)
    );

    int total = 0;
    int bad   = 0;
    logic [11:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp1(input string tag);
        logic [11:0] e;
        chk({tag, "_sb"}, sb.size(), 1);
        e = (sb.size() > 0) ? sb.pop_front() : 12'h000;
        chk({tag, "_valid"}, rv_1, 1'b1);
        chk({tag, "_id"}, rid_1, e[11]);
        chk({tag, "_y"}, ry_1, e[10:3]);
        chk({tag, "_flags"}, rf_1, e[2:0]);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       exp_id;
        logic [7:0] exp_a;
        logic [11:0] e3;
        rst = 1'b1;
        {a0, b0, a1, b1} = '0;
        {op0, op1, sh0, sh1} = '0;
        {sy, scero, scarry, sov} = '0;
        {v0_1, v1_1, rr_1, v0_3, v1_3, rr_3} = '0;
        #2 rst = 1'b0;
        v0_1 = 1'b1; v1_1 = 1'b1; v0_3 = 1'b1;
        #10;
        chk("rst_ready0", r0_1, 1'b0);
        chk("rst_ready1", r1_1, 1'b0);
        chk("rst_ready0_l3", r0_3, 1'b0);
        chk("rst_rsp_valid", rv_1, 1'b0);
        chk("rst_busy", busy_1, 1'b0);
        chk("rst_rsp_id", rid_1, 1'b0);
        chk("rst_rsp_y", ry_1, 8'h00);
        chk("rst_rsp_flags", rf_1, 3'b000);
        chk("rst_alu_ab", {aa_1, ab_1}, 16'h0000);
        chk("rst_alu_s_shift", {as_1, ash_1}, 7'h00);
        chk("rst_op_count", oc_1, 16'h0000);
        v0_1 = 1'b0; v1_1 = 1'b0; v0_3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // single op from requester 0, LAT=1
        @(negedge clk);
        a0 = 8'h05; b0 = 8'h03; op0 = 3'd0; sh0 = 4'd0;
        sy = 8'h08; v0_1 = 1'b1; rr_1 = 1'b1;
        #1;
        chk("a_ready0", r0_1, 1'b1);
        chk("a_ready1", r1_1, 1'b0);
        sb.push_back({1'b0, 8'h08, 3'b000});
        @(negedge clk);
        chk("a_alu_a", aa_1, 8'h05);
        chk("a_alu_b", ab_1, 8'h03);
        chk("a_busy", busy_1, 1'b1);
        chk("a_no_rsp_yet", rv_1, 1'b0);
        v0_1 = 1'b0;
        @(negedge clk);
        check_rsp1("a_rsp");
        @(negedge clk);
        chk("a_rsp_done", rv_1, 1'b0);
        chk("a_op_count", oc_1, 16'd1);
        chk("a_alu_a_held", aa_1, 8'h05);

        // reset, then both requesters valid continuously: 0,1,0,1 every 3 cycles
        @(negedge clk);
        rst = 1'b0;
        #1 rst = 1'b1;
        a0 = 8'h20; a1 = 8'h40; v0_1 = 1'b1; v1_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_id = i[0];
            chk($sformatf("rr_ready0_%0d", i), r0_1, !exp_id);
            chk($sformatf("rr_ready1_%0d", i), r1_1, exp_id);
            exp_a = exp_id ? a1 : a0;
            sy = 8'h10 + 8'(i);
            sb.push_back({exp_id, sy, 3'b000});
            @(negedge clk);
            chk($sformatf("rr_alu_a_%0d", i), aa_1, exp_a);
            chk($sformatf("rr_busy_%0d", i), busy_1, 1'b1);
            @(negedge clk);
            check_rsp1($sformatf("rr_rsp_%0d", i));
            chk($sformatf("rr_no_ready_hs_%0d", i), {r0_1, r1_1}, 2'b00);
            a0 = 8'h21 + 8'(i); a1 = 8'h41 + 8'(i);
            @(negedge clk);
        end
        v0_1 = 1'b0; v1_1 = 1'b0;
        chk("rr_op_count", oc_1, 16'd4);

        // operand change while waiting, then flag capture
        @(negedge clk);
        v0_1 = 1'b1; a0 = 8'h33; v1_1 = 1'b1; a1 = 8'h11; sy = 8'h55;
        #1;
        chk("c_ready0", r0_1, 1'b1);
        chk("c_ready1", r1_1, 1'b0);
        sb.push_back({1'b0, 8'h55, 3'b000});
        @(negedge clk);
        v0_1 = 1'b0;
        chk("c_ready1_exec", r1_1, 1'b0);
        @(negedge clk);
        check_rsp1("c_rsp0");
        chk("c_ready1_resp", r1_1, 1'b0);
        a1 = 8'h22; sy = 8'h00; scero = 1'b1; scarry = 1'b1; sov = 1'b0;
        @(negedge clk);
        #1;
        chk("c_ready1_idle", r1_1, 1'b1);
        sb.push_back({1'b1, 8'h00, 3'b011});
        @(negedge clk);
        chk("c_alu_a_late", aa_1, 8'h22);
        v1_1 = 1'b0;
        @(negedge clk);
        check_rsp1("c_rsp1");
        @(negedge clk);
        chk("c_op_count", oc_1, 16'd6);
        scero = 1'b0; scarry = 1'b0;

        // asynchronous reset in the middle of EXEC
        @(negedge clk);
        v0_1 = 1'b1; a0 = 8'h77; sy = 8'h99;
        #1;
        chk("d_ready0", r0_1, 1'b1);
        @(negedge clk);
        v0_1 = 1'b0;
        chk("d_busy_exec", busy_1, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("d_rsp_valid", rv_1, 1'b0);
        chk("d_busy", busy_1, 1'b0);
        chk("d_alu", {aa_1, ab_1, as_1, ash_1}, 23'h0);
        chk("d_rsp", {rid_1, ry_1, rf_1}, 12'h000);
        chk("d_op_count", oc_1, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("d_no_rsp_%0d", k), {rv_1, busy_1}, 2'b00);
        end

        // op_count wrap
        @(negedge clk);
        force u1.opcnt_q = 16'hFFFF;
        @(negedge clk);
        release u1.opcnt_q;
        chk("e_preload", oc_1, 16'hFFFF);
        v0_1 = 1'b1; a0 = 8'h01; sy = 8'h42;
        #1;
        chk("e_ready0", r0_1, 1'b1);
        sb.push_back({1'b0, 8'h42, 3'b000});
        @(negedge clk);
        v0_1 = 1'b0;
        @(negedge clk);
        check_rsp1("e_rsp");
        @(negedge clk);
        chk("e_wrap", oc_1, 16'h0000);

        // LAT=3 with a stalled consumer
        @(negedge clk);
        v0_3 = 1'b1; a0 = 8'h0A; b0 = 8'h0B; op0 = 3'd5; sh0 = 4'd9;
        sy = 8'hC3; scero = 1'b0; scarry = 1'b1; sov = 1'b1; rr_3 = 1'b0;
        #1;
        chk("l3_ready0", r0_3, 1'b1);
        sb.push_back({1'b0, 8'hC3, 3'b110});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            a0 = 8'hEE;
            chk($sformatf("l3_exec_valid_%0d", k), rv_3, 1'b0);
            chk($sformatf("l3_exec_busy_%0d", k), busy_3, 1'b1);
            chk($sformatf("l3_exec_ready_%0d", k), r0_3, 1'b0);
        end
        e3 = (sb.size() > 0) ? sb[0] : 12'h000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                sy = 8'h00; scarry = 1'b0; sov = 1'b0;
            end
            chk($sformatf("l3_hold_valid_%0d", k), rv_3, 1'b1);
            chk($sformatf("l3_hold_rsp_%0d", k), {rid_3, ry_3, rf_3}, e3);
            chk($sformatf("l3_hold_alu_%0d", k), {aa_3, ab_3, as_3, ash_3}, {8'h0A, 8'h0B, 3'd5, 4'd9});
            chk($sformatf("l3_hold_ready_%0d", k), r0_3, 1'b0);
        end
        @(negedge clk);
        chk("l3_hs_valid", rv_3, 1'b1);
        chk("l3_hs_ready0", r0_3, 1'b0);
        rr_3 = 1'b1;
        v0_3 = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);
        chk("l3_done_valid", rv_3, 1'b0);
        chk("l3_op_count", oc_3, 16'd1);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
